// File: rtl/timer_multi.sv
// Multi-channel timer/compare block on the 68000-style 16-bit peripheral bus.
// NCH up-counters share one free-running prescaler; sticky match flags drive a maskable irq.
module timer_multi #(
   parameter int NCH     = 2,
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [15:0]      data_write,
   output logic [15:0]      data_read,
   input  logic [7:0]       addr,
   input  logic             uds,
   input  logic             lds,
   input  logic             rw,
   output logic             ack,
   output logic [NCH-1:0]   match,
   output logic             irq
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t               r_state;
   logic                 r_ack;
   logic [15:0]          r_data_read;
   logic [PRESC_W-1:0]   r_presc;
   logic [WIDTH-1:0]     r_count [NCH];
   logic [WIDTH-1:0]     r_cmp   [NCH];
   logic [4:0]           r_div   [NCH];
   logic [NCH-1:0]       r_en;
   logic [NCH-1:0]       r_os;
   logic [NCH-1:0]       r_ie;
   logic [NCH-1:0]       r_flag;
   logic [NCH-1:0]       r_match;

   logic                 w_access;
   logic                 w_wr;
   logic [3:0]           w_ch;
   logic [2:0]           w_off;
   logic [15:0]          w_lane;
   logic [15:0]          w_rd_word;
   logic                 w_unused_addr0;

   logic [WIDTH-1:0]     w_cnt_nx [NCH];
   logic [WIDTH-1:0]     w_cmp_nx [NCH];
   logic [4:0]           w_div_nx [NCH];
   logic [NCH-1:0]       w_en_nx;
   logic [NCH-1:0]       w_os_nx;
   logic [NCH-1:0]       w_ie_nx;
   logic [NCH-1:0]       w_flag_nx;
   logic [NCH-1:0]       w_hit;

   function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic        up,
                                              input logic        lo);
      logic [15:0] res;
      res = old_v;
      if (up) res[15:8] = new_v[15:8];
      if (lo) res[7:0]  = new_v[7:0];
      return res;
   endfunction

   function automatic logic [4:0] clamp_div(input logic [4:0] d);
      if (int'(d) >= PRESC_W) return 5'(PRESC_W - 1);
      return d;
   endfunction

   assign w_access       = (r_state == S_IDLE) && (uds || lds);
   assign w_wr           = w_access && !rw;
   assign w_ch           = addr[7:4];
   assign w_off          = addr[3:1];
   assign w_lane         = {{8{uds}}, {8{lds}}};
   assign w_unused_addr0 = addr[0];

   // Register map read mux; unmapped offsets and absent channels fall through to 0.
   always_comb begin
      w_rd_word = 16'h0000;
      for (int n = 0; n < NCH; n++) begin
         if (w_ch == 4'(n)) begin
            case (w_off)
               3'd0:    w_rd_word = 16'(32'(r_count[n]) >> 16);
               3'd1:    w_rd_word = 16'(32'(r_count[n]));
               3'd2:    w_rd_word = 16'(32'(r_cmp[n]) >> 16);
               3'd3:    w_rd_word = 16'(32'(r_cmp[n]));
               3'd4:    w_rd_word = {8'h00, r_div[n], r_ie[n], r_os[n], r_en[n]};
               3'd5:    w_rd_word = {15'h0000, r_flag[n]};
               default: w_rd_word = 16'h0000;
            endcase
         end
      end
   end

   // Tick update first, then bus writes overlay only the bytes they strobe.
   always_comb begin
      logic [PRESC_W-1:0] w_mask;
      logic [WIDTH-1:0]   w_inc;
      logic [31:0]        w_c32;
      logic [31:0]        w_m32;
      logic               w_tick;
      logic               w_sel;
      w_mask = '0;
      w_inc  = '0;
      w_c32  = '0;
      w_m32  = '0;
      w_tick = 1'b0;
      w_sel  = 1'b0;
      for (int n = 0; n < NCH; n++) begin
         w_mask       = ~({PRESC_W{1'b1}} << r_div[n]);
         w_tick       = (r_presc & w_mask) == w_mask;
         w_hit[n]     = r_en[n] && w_tick && (r_count[n] == r_cmp[n]);
         w_inc        = r_count[n] + WIDTH'(1);
         w_en_nx[n]   = (w_hit[n] && r_os[n]) ? 1'b0 : r_en[n];
         w_os_nx[n]   = r_os[n];
         w_ie_nx[n]   = r_ie[n];
         w_div_nx[n]  = r_div[n];
         w_flag_nx[n] = r_flag[n];
         if (w_hit[n])
            w_c32 = 32'h0;
         else if (r_en[n] && w_tick)
            w_c32 = 32'(w_inc);
         else
            w_c32 = 32'(r_count[n]);
         w_m32 = 32'(r_cmp[n]);
         w_sel = w_wr && (w_ch == 4'(n));
         if (w_sel) begin
            case (w_off)
               3'd0: w_c32[31:16] = lane_merge(w_c32[31:16], data_write, uds, lds);
               3'd1: w_c32[15:0]  = lane_merge(w_c32[15:0],  data_write, uds, lds);
               3'd2: w_m32[31:16] = lane_merge(w_m32[31:16], data_write, uds, lds);
               3'd3: w_m32[15:0]  = lane_merge(w_m32[15:0],  data_write, uds, lds);
               3'd4: if (lds) begin
                  w_en_nx[n]  = data_write[0];
                  w_os_nx[n]  = data_write[1];
                  w_ie_nx[n]  = data_write[2];
                  w_div_nx[n] = clamp_div(data_write[7:3]);
               end
               3'd5: if (lds && data_write[0]) w_flag_nx[n] = 1'b0;
               default: ;
            endcase
         end
         if (w_hit[n]) w_flag_nx[n] = 1'b1;
         w_cnt_nx[n] = WIDTH'(w_c32);
         w_cmp_nx[n] = WIDTH'(w_m32);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_ack       <= 1'b0;
         r_data_read <= 16'h0000;
         r_presc     <= '0;
         r_en        <= '0;
         r_os        <= '0;
         r_ie        <= '0;
         r_flag      <= '0;
         r_match     <= '0;
         for (int n = 0; n < NCH; n++) begin
            r_count[n] <= '0;
            r_cmp[n]   <= '0;
            r_div[n]   <= '0;
         end
      end else begin
         r_presc <= r_presc + PRESC_W'(1);
         r_en    <= w_en_nx;
         r_os    <= w_os_nx;
         r_ie    <= w_ie_nx;
         r_flag  <= w_flag_nx;
         r_match <= w_hit;
         for (int n = 0; n < NCH; n++) begin
            r_count[n] <= w_cnt_nx[n];
            r_cmp[n]   <= w_cmp_nx[n];
            r_div[n]   <= w_div_nx[n];
         end
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: if (uds || lds) begin
               r_ack   <= 1'b1;
               r_state <= S_WAIT;
               if (rw) r_data_read <= w_rd_word & w_lane;
            end
            S_WAIT: if (!uds && !lds) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_read = r_data_read;
   assign ack       = r_ack;
   assign match     = r_match;
   assign irq       = |(r_flag & r_ie);

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: cycle-level reference model for the default build plus directed WIDTH=8 checks.
module tb_timer_multi;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] data_write = 16'h0;
   logic [7:0]  addr = 8'h0;
   logic        uds = 1'b0, lds = 1'b0, rw = 1'b1;
   logic        uds8 = 1'b0, lds8 = 1'b0;
   logic [15:0] data_read, data_read8;
   logic        ack, ack8, irq, irq8;
   logic [1:0]  match, match8;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   timer_multi #(.NCH(2), .WIDTH(32), .PRESC_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .data_write(data_write), .data_read(data_read),
      .addr(addr), .uds(uds), .lds(lds), .rw(rw), .ack(ack), .match(match), .irq(irq));

   timer_multi #(.NCH(2), .WIDTH(8), .PRESC_W(16)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .data_write(data_write), .data_read(data_read8),
      .addr(addr), .uds(uds8), .lds(lds8), .rw(rw), .ack(ack8), .match(match8), .irq(irq8));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model of the default instance, stated in terms of the register-level rules.
   longint unsigned m_cnt [2];
   longint unsigned m_cmp [2];
   int              m_div [2];
   bit              m_en [2], m_os [2], m_ie [2], m_flag [2];
   int              m_presc;
   bit              m_busy;
   logic            m_ack = 1'b0;
   logic [15:0]     m_rd = 16'h0;
   logic [1:0]      m_match = 2'b0;

   function automatic logic [15:0] m_reg(input int ch, input int off);
      if (ch >= 2) return 16'h0;
      case (off)
         0: return 16'(m_cnt[ch] >> 16);
         1: return 16'(m_cnt[ch]);
         2: return 16'(m_cmp[ch] >> 16);
         3: return 16'(m_cmp[ch]);
         4: return 16'((m_div[ch] << 3) | (int'(m_ie[ch]) << 2) | (int'(m_os[ch]) << 1) | int'(m_en[ch]));
         5: return 16'(int'(m_flag[ch]));
         default: return 16'h0;
      endcase
   endfunction

   function automatic longint unsigned put16(input longint unsigned old, input int sh,
                                             input logic [15:0] d, input bit u, input bit l);
      longint unsigned r;
      r = old;
      if (u) r = (r & ~(64'hFF << (sh + 8))) | (64'(d[15:8]) << (sh + 8));
      if (l) r = (r & ~(64'hFF << sh)) | (64'(d[7:0]) << sh);
      return r & 64'hFFFF_FFFF;
   endfunction

   always @(posedge clk) begin
      int ch, off, dv;
      bit acc, wr;
      logic [1:0] hit;
      if (!reset_n) begin
         for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0; m_cmp[c] = 0; m_div[c] = 0;
            m_en[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
         end
         m_presc = 0; m_busy = 0; m_ack = 0; m_rd = 16'h0; m_match = 2'b0;
      end else begin
         ch  = int'(addr[7:4]);
         off = int'(addr[3:1]);
         acc = !m_busy && (uds || lds);
         m_ack = acc;
         if (acc && rw) m_rd = m_reg(ch, off) & {uds ? 8'hFF : 8'h00, lds ? 8'hFF : 8'h00};
         if (acc) m_busy = 1;
         else if (!uds && !lds) m_busy = 0;
         wr = acc && !rw && ch < 2;
         if (wr && off == 5 && lds && data_write[0]) m_flag[ch] = 0;
         hit = 2'b0;
         for (int c = 0; c < 2; c++) begin
            if (m_en[c] && (m_presc % (1 << m_div[c])) == (1 << m_div[c]) - 1) begin
               if (m_cnt[c] == m_cmp[c]) begin
                  m_cnt[c] = 0; m_flag[c] = 1; hit[c] = 1'b1;
                  if (m_os[c]) m_en[c] = 0;
               end else begin
                  m_cnt[c] = (m_cnt[c] + 1) % (64'd1 << 32);
               end
            end
         end
         if (wr) begin
            case (off)
               0: m_cnt[ch] = put16(m_cnt[ch], 16, data_write, uds, lds);
               1: m_cnt[ch] = put16(m_cnt[ch], 0, data_write, uds, lds);
               2: m_cmp[ch] = put16(m_cmp[ch], 16, data_write, uds, lds);
               3: m_cmp[ch] = put16(m_cmp[ch], 0, data_write, uds, lds);
               4: if (lds) begin
                  m_en[ch] = data_write[0];
                  m_os[ch] = data_write[1];
                  m_ie[ch] = data_write[2];
                  dv = int'(data_write[7:3]);
                  m_div[ch] = (dv > 15) ? 15 : dv;
               end
               default: ;
            endcase
         end
         m_match = hit;
         m_presc = (m_presc + 1) % 65536;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("ack", 32'(ack), 32'(m_ack));
         check("match", 32'(match), 32'(m_match));
         check("irq", 32'(irq), 32'((m_flag[0] & m_ie[0]) | (m_flag[1] & m_ie[1])));
         check("data_read", 32'(data_read), 32'(m_rd));
      end
   end

   // Called at a negedge; holds the strobes for 'hold' cycles and expects exactly one ack.
   task automatic bus(input bit sel, input bit rd, input logic [7:0] a, input logic [15:0] d,
                      input bit u, input bit l, input int hold, output logic [15:0] q);
      int acks;
      acks = 0;
      q = 16'hFFFF;
      addr = a; data_write = d; rw = rd;
      if (sel) begin uds8 = u; lds8 = l; end
      else     begin uds = u;  lds = l;  end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (sel ? ack8 : ack) begin
            acks++;
            q = sel ? data_read8 : data_read;
         end
      end
      uds = 0; lds = 0; uds8 = 0; lds8 = 0; rw = 1;
      @(negedge clk);
      if (sel ? ack8 : ack) acks++;
      check("ack_count", 32'(acks), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] q;
      int pulses, first;
      bit rd, u, l;
      int s, ch, off;
      logic [15:0] d;

      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;

      // Reset state of every register, including an absent channel.
      for (int c = 0; c < 3; c++)
         for (int o = 0; o < 6; o++) begin
            bus(0, 1, 8'((c << 4) | (o << 1)), 16'h0, 1, 1, 1, q);
            check("rst_read", 32'(q), 32'h0);
         end

      // Ch0 periodic, cmp=4, div 0.
      bus(0, 0, 8'h06, 16'h0004, 1, 1, 1, q);
      bus(0, 0, 8'h08, 16'h0005, 1, 1, 1, q);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (match[0]) pulses++;
      end
      check("ch0_pulses", 32'(pulses), 32'd4);
      check("ch0_irq", 32'(irq), 32'd1);
      bus(0, 0, 8'h08, 16'h0004, 1, 1, 1, q);
      bus(0, 0, 8'h0A, 16'h0001, 0, 1, 10, q);
      check("w1c_irq", 32'(irq), 32'd0);

      // Ch1 one-shot, cmp=2, div 2.
      bus(0, 0, 8'h16, 16'h0002, 1, 1, 1, q);
      bus(0, 0, 8'h18, 16'h0013, 1, 1, 1, q);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (match[1]) pulses++;
      end
      check("ch1_pulses", 32'(pulses), 32'd1);
      bus(0, 1, 8'h18, 16'h0, 1, 1, 1, q);
      check("ch1_ctrl", 32'(q), 32'h0012);
      bus(0, 1, 8'h12, 16'h0, 1, 1, 1, q);
      check("ch1_cnt_lo", 32'(q), 32'h0);

      // Long-held count write, then byte-lane write on a running counter.
      bus(0, 0, 8'h02, 16'h1234, 1, 1, 10, q);
      bus(0, 1, 8'h02, 16'h0, 1, 1, 1, q);
      check("hold_write", 32'(q), 32'h1234);
      bus(0, 0, 8'h04, 16'hFFFF, 1, 1, 1, q);
      bus(0, 0, 8'h08, 16'h0001, 1, 1, 1, q);
      bus(0, 0, 8'h02, 16'hAB00, 1, 0, 1, q);
      bus(0, 1, 8'h02, 16'h0, 1, 0, 1, q);
      check("uds_read", 32'(q), 32'hAB00);
      bus(0, 1, 8'h02, 16'h0, 0, 1, 1, q);
      check("lds_upper", 32'(q & 16'hFF00), 32'h0);
      bus(0, 0, 8'h08, 16'h0000, 1, 1, 1, q);

      // Randomised traffic against the model.
      for (int k = 0; k < 400; k++) begin
         ch  = $urandom_range(0, 2);
         off = $urandom_range(0, 7);
         rd  = 1'($urandom_range(0, 1));
         s   = $urandom_range(1, 3);
         u   = s[1];
         l   = s[0];
         d   = 16'($urandom);
         if (off == 0 || off == 2) d = 16'($urandom_range(0, 1));
         bus(0, rd, 8'((ch << 4) | (off << 1) | $urandom_range(0, 1)), d, u, l,
             $urandom_range(1, 3), q);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset in the middle of an access.
      addr = 8'h02; rw = 1; uds = 1; lds = 1;
      @(negedge clk);
      check("ack_pre_rst", 32'(ack), 32'd1);
      reset_n = 0; uds = 0; lds = 0;
      @(negedge clk);
      check("ack_rst", 32'(ack), 32'd0);
      reset_n = 1;
      @(negedge clk);

      // WIDTH=8 build.
      bus(1, 0, 8'h06, 16'h00FF, 1, 1, 1, q);
      bus(1, 0, 8'h04, 16'hFFFF, 1, 1, 1, q);
      bus(1, 0, 8'h00, 16'hFFFF, 1, 1, 1, q);
      bus(1, 0, 8'h02, 16'h00FE, 1, 1, 1, q);
      bus(1, 0, 8'h08, 16'h0001, 1, 1, 1, q);
      first = -1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (match8[0]) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      check("w8_match_at", 32'(first), 32'd0);
      check("w8_pulses", 32'(pulses), 32'd1);
      bus(1, 0, 8'h08, 16'h0000, 1, 1, 1, q);
      bus(1, 1, 8'h00, 16'h0, 1, 1, 1, q);
      check("w8_cnt_hi", 32'(q), 32'h0);
      bus(1, 1, 8'h04, 16'h0, 1, 1, 1, q);
      check("w8_cmp_hi", 32'(q), 32'h0);
      bus(1, 1, 8'h06, 16'h0, 1, 1, 1, q);
      check("w8_cmp_lo", 32'(q), 32'h00FF);
      bus(1, 0, 8'h26, 16'h5555, 1, 1, 1, q);
      bus(1, 1, 8'h26, 16'h0, 1, 1, 1, q);
      check("w8_ch2_read", 32'(q), 32'h0);
      check("w8_irq", 32'(irq8), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised multi-channel timer/compare block on the 68000-style 16-bit peripheral bus (uds/lds/rw/ack).
- NCH independent up-counters share one free-running prescaler. Each counter has a per-channel clock divider, a compare register, periodic or one-shot mode, and a sticky match flag.
- A combined, maskable interrupt request goes to the CPU interrupt encoder.

Parameters:
- NCH, 2, number of channels, 1..8
- WIDTH, 32, counter/compare width in bits, 1..32
- PRESC_W, 16, shared prescaler width; clk_div field range 0..PRESC_W-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- data_write  in  16  bus write data; [15:8] upper lane, [7:0] lower lane
- data_read  out  16  bus read data, registered
- addr  in  8  byte address; addr[0] ignored
- uds  in  1  upper byte strobe
- lds  in  1  lower byte strobe
- rw  in  1  1 = read, 0 = write
- ack  out  1  one-cycle access acknowledge
- match  out  NCH  per-channel one-cycle pulse on compare match
- irq  out  1  OR over channels of (flag & irq_en), combinational from registers

Behaviour:
- Clock and reset: clock clk; reset reset_n, synchronous, active-low.
- Reset values: all counters, compares and ctrl = 0; flags = 0; prescaler = 0; data_read = 0; ack = 0; match = 0; irq = 0.
- Register map: channel n at base n*16 (addr[7:4] = n). Word offsets addr[3:1]:
  - 0: count[31:16]
  - 1: count[15:0]
  - 2: cmp[31:16]
  - 3: cmp[15:0]
  - 4: ctrl
  - 5: status
- Bits above WIDTH read 0 and ignore writes. Unmapped offsets and channels >= NCH read 0 and ignore writes, but are still acked.
- ctrl[7:0], lower lane, fields:
  - bit0 enable
  - bit1 oneshot
  - bit2 irq_en
  - bits[7:3] clk_div, values >= PRESC_W clamp to PRESC_W-1
  - ctrl[15:8] reads 0.
- status: bit0 = flag, read-only except write-1-to-clear via lds. Other bits read 0.
- Byte lanes: uds writes the upper byte, lds writes the lower byte, independently. On read, an unstrobed lane returns 0.
- Bus handshake, two states IDLE/WAIT:
  - IDLE with (uds|lds): perform the access in that cycle (write takes effect, read data is latched); ack = 1 next cycle; go to WAIT.
  - WAIT: ack = 0; return to IDLE when uds = lds = 0.
  - Result: exactly one ack and one side effect per strobe assertion, however long the strobes are held.
- Prescaler: PRESC_W-bit counter, +1 every clk, wraps, never stops.
- Channel tick: (presc & mask) == mask, with mask = 2^clk_div - 1. Tick period is 2^clk_div clocks; clk_div = 0 ticks every cycle.
- Per channel, on enable & tick:
  - If count == cmp: count <= 0; flag <= 1; match[n] pulses one cycle (next cycle); if oneshot, enable <= 0.
  - Else count <= count + 1, wrapping modulo 2^WIDTH.
- Channels run independently; a disabled channel holds its count.
- Simultaneous events:
  - A bus write to count/ctrl in the same cycle as a tick update: the bus write wins for the written bytes. Unwritten bytes take the tick result.
  - Flag set and W1C in the same cycle: set wins.
  - A one-shot enable clear coinciding with a ctrl write: the ctrl write wins.
- cmp = 0 in periodic mode: match on every tick, count stays 0.
- Reset mid-access returns the handshake to IDLE with ack = 0.

Test Plan:
- Reset, then read all channel registers -> all 0x0000, ack high exactly one cycle per access, irq = 0.
- Ch0: cmp = 4, ctrl = 0x0005 (enable, irq_en, div 0) -> match[0] pulses every 5 clocks; flag = 1; irq = 1; write status 0x0001 -> irq = 0 until the next match.
- Ch1: cmp = 2, ctrl = 0x0013 (oneshot, div 2) -> count advances every 4 clocks; one match pulse; enable reads back 0; count = 0 and stays there.
- Hold uds/lds asserted 10 cycles on a status W1C or count write -> single ack, single write effect.
- Byte-lane write: uds only, 0xAB00 to ch0 offset 1 -> count[15:8] = 0xAB, count[7:0] keeps its running value; lds-only read returns upper lane 0x00.
- WIDTH = 8 build: cmp = 0xFF, count preset 0xFE -> match after 2 ticks; count[31:8] reads 0; access to channel NCH returns 0 and is acked.
